hram_cmd_sequencer: RTL and testbench



---
 rtl/hram_cmd_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_hram_cmd_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hram_cmd_sequencer.sv
`timescale 1ns/1ps
// Command sequencer between the UART pair and the HyperRAM controller: collects
// 5-byte frames, executes them, and answers every accepted frame with 5 bytes.
module hram_cmd_sequencer #(
  parameter int unsigned RX_GAP_TIMEOUT = 24000,
  parameter int unsigned HRAM_TIMEOUT   = 4096,
  parameter logic [31:0] CONST_VALUE    = 32'd259
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_ready,
  output logic [31:0] hram_addr,
  output logic [31:0] hram_wr_d,
  output logic        hram_wr_req,
  output logic        hram_rd_req,
  input  logic        hram_busy,
  input  logic [31:0] hram_rd_d,
  input  logic        hram_rd_rdy,
  output logic        overrun
);

  typedef enum logic [2:0] {
    S_COLLECT,
    S_EXEC,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [7:0] CMD_ADDR     = 8'h01;
  localparam logic [7:0] CMD_LOAD     = 8'h02;
  localparam logic [7:0] CMD_WRITE    = 8'h03;
  localparam logic [7:0] CMD_READ     = 8'h04;
  localparam logic [7:0] CMD_READ_REQ = 8'h05;
  localparam logic [7:0] CMD_COUNT    = 8'h06;
  localparam logic [7:0] CMD_CONST    = 8'h07;
  localparam logic [7:0] RSP_BAD_CMD  = 8'hFF;
  localparam logic [7:0] RSP_TIMEOUT  = 8'hEE;

  localparam int GAP_W = $clog2(RX_GAP_TIMEOUT + 1);
  localparam int HTO_W = $clog2(HRAM_TIMEOUT + 1);

  state_t             state;
  state_t             state_next;
  logic [39:0]        frame;
  logic [2:0]         byte_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [HTO_W-1:0]   hto_cnt;
  logic [31:0]        rd_latch;
  logic [31:0]        count_q;
  logic [39:0]        resp;
  logic [2:0]         tx_idx;
  logic               tx_sent;
  logic               seen_busy;

  logic [7:0]  cmd;
  logic [31:0] data;
  logic        is_read;
  logic        is_issue;
  logic        hto_expired;
  logic        wait_done;

  assign cmd         = frame[39:32];
  assign data        = frame[31:0];
  assign is_read     = (cmd == CMD_READ_REQ);
  assign is_issue    = (cmd == CMD_WRITE) || (cmd == CMD_READ_REQ);
  assign hto_expired = (hto_cnt == HTO_W'(HRAM_TIMEOUT));
  // A write completes only after busy has been seen high and then low again.
  assign wait_done   = is_read ? hram_rd_rdy : (seen_busy && !hram_busy);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_COLLECT;
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next  = state;
    tx_start    = 1'b0;
    tx_data     = 8'h00;
    hram_wr_req = 1'b0;
    hram_rd_req = 1'b0;
    case (state)
      S_COLLECT: if (rx_valid && byte_cnt == 3'd4) state_next = S_EXEC;
      S_EXEC:    state_next = is_issue ? S_ISSUE : S_RESP;
      S_ISSUE: begin
        if (hto_expired) begin
          state_next = S_RESP;
        end else if (!hram_busy) begin
          hram_wr_req = !is_read;
          hram_rd_req = is_read;
          state_next  = S_WAIT;
        end
      end
      S_WAIT: if (wait_done || hto_expired) state_next = S_RESP;
      S_RESP: begin
        tx_data = resp[39:32];
        if (!tx_sent)                             tx_start   = tx_ready;
        else if (!tx_ready && tx_idx == 3'd4)     state_next = S_COLLECT;
      end
      default: state_next = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame     <= '0;
      byte_cnt  <= '0;
      gap_cnt   <= '0;
      hto_cnt   <= '0;
      hram_addr <= '0;
      hram_wr_d <= '0;
      rd_latch  <= '0;
      count_q   <= '0;
      resp      <= '0;
      tx_idx    <= '0;
      tx_sent   <= 1'b0;
      seen_busy <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (rx_valid && state != S_COLLECT) overrun <= 1'b1;
      case (state)
        S_COLLECT: begin
          if (rx_valid) begin
            frame    <= {frame[31:0], rx_data};
            byte_cnt <= (byte_cnt == 3'd4) ? 3'd0 : byte_cnt + 3'd1;
            gap_cnt  <= '0;
          end else if (byte_cnt != 3'd0) begin
            // A stalled partial frame is dropped silently.
            if (gap_cnt == GAP_W'(RX_GAP_TIMEOUT)) begin
              byte_cnt <= '0;
              gap_cnt  <= '0;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
        end
        S_EXEC: begin
          hto_cnt   <= '0;
          seen_busy <= 1'b0;
          tx_idx    <= '0;
          tx_sent   <= 1'b0;
          case (cmd)
            CMD_ADDR: begin
              hram_addr <= data;
              resp      <= {cmd, data};
            end
            CMD_LOAD: begin
              hram_wr_d <= data;
              resp      <= {cmd, data};
            end
            CMD_WRITE, CMD_READ_REQ: begin
            end
            CMD_READ:  resp <= {cmd, rd_latch};
            CMD_COUNT: begin
              resp    <= {cmd, count_q};
              count_q <= count_q + 32'd1;
            end
            CMD_CONST: resp <= {cmd, CONST_VALUE};
            default:   resp <= {RSP_BAD_CMD, data};
          endcase
        end
        S_ISSUE, S_WAIT: begin
          hto_cnt <= hto_cnt + HTO_W'(1);
          if (state == S_WAIT && hram_busy) seen_busy <= 1'b1;
          if (state == S_WAIT && wait_done) begin
            resp <= {cmd, (is_read ? hram_rd_d : 32'h0000_0003)};
            if (is_read) rd_latch <= hram_rd_d;
          end else if (hto_expired) begin
            resp <= {RSP_TIMEOUT, hram_addr};
          end
        end
        S_RESP: begin
          // Each byte: strobe when ready, then hold off until the transmitter goes busy.
          if (!tx_sent) begin
            if (tx_ready) tx_sent <= 1'b1;
          end else if (!tx_ready) begin
            tx_sent <= 1'b0;
            tx_idx  <= tx_idx + 3'd1;
            resp    <= {resp[31:0], 8'h00};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hram_cmd_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for hram_cmd_sequencer: directed frames push their expected
// response bytes; a monitor pops and compares on every tx_start.
module tb_hram_cmd_sequencer;

  localparam int unsigned RX_GAP   = 100;
  localparam int unsigned HRAM_TO  = 64;
  localparam int          BUSY_LEN = 10;
  localparam int          RD_DELAY = 20;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_ready;
  logic [31:0] hram_addr;
  logic [31:0] hram_wr_d;
  logic        hram_wr_req;
  logic        hram_rd_req;
  logic        hram_busy;
  logic [31:0] hram_rd_d;
  logic        hram_rd_rdy;
  logic        overrun;

  logic        busy_model, busy_force;
  logic        rd_rdy_model, rd_rdy_force;
  logic [31:0] rd_d_model, rd_d_force, rd_val;
  assign hram_busy   = busy_model | busy_force;
  assign hram_rd_rdy = rd_rdy_model | rd_rdy_force;
  assign hram_rd_d   = rd_rdy_force ? rd_d_force : rd_d_model;

  int          wr_cnt, rd_cnt, both_cnt, tx_seen;
  logic [31:0] wr_d_seen, wr_addr_seen, rd_addr_seen;
  logic [7:0]  exp_q[$];
  logic [7:0]  mon_exp;
  int          n_checks, n_pass;
  int          lat;

  hram_cmd_sequencer #(
    .RX_GAP_TIMEOUT(RX_GAP),
    .HRAM_TIMEOUT  (HRAM_TO),
    .CONST_VALUE   (32'd259)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_ready   (tx_ready),
    .hram_addr  (hram_addr),
    .hram_wr_d  (hram_wr_d),
    .hram_wr_req(hram_wr_req),
    .hram_rd_req(hram_rd_req),
    .hram_busy  (hram_busy),
    .hram_rd_d  (hram_rd_d),
    .hram_rd_rdy(hram_rd_rdy),
    .overrun    (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
  endtask

  // UART transmitter model: ready drops 1 or 2 cycles after a start, busy for 6 cycles.
  initial begin
    logic slow;
    slow     = 1'b0;
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_start && !reset) begin
        slow = ~slow;
        @(posedge clk); #1;
        if (slow) begin @(posedge clk); #1; end
        tx_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1 tx_ready = 1'b1;
      end
    end
  end

  // HyperRAM controller model.
  initial begin
    busy_model   = 1'b0;
    rd_rdy_model = 1'b0;
    rd_d_model   = '0;
    wr_cnt       = 0;
    rd_cnt       = 0;
    forever begin
      @(negedge clk);
      if (hram_wr_req) begin
        wr_cnt++;
        wr_d_seen    = hram_wr_d;
        wr_addr_seen = hram_addr;
        @(posedge clk); #1 busy_model = 1'b1;
        repeat (BUSY_LEN) @(posedge clk);
        #1 busy_model = 1'b0;
      end else if (hram_rd_req) begin
        rd_cnt++;
        rd_addr_seen = hram_addr;
        @(posedge clk); #1 busy_model = 1'b1;
        repeat (RD_DELAY - 1) @(posedge clk);
        #1;
        busy_model   = 1'b0;
        rd_rdy_model = 1'b1;
        rd_d_model   = rd_val;
        @(posedge clk); #1;
        rd_rdy_model = 1'b0;
        rd_d_model   = '0;
      end
    end
  end

  // Monitor: every tx_start must match the head of the expected-byte queue.
  initial begin
    tx_seen  = 0;
    both_cnt = 0;
    forever begin
      @(negedge clk);
      if (hram_wr_req && hram_rd_req) both_cnt++;
      if (!reset && tx_start) begin
        check($sformatf("tx_ready_at_start[%0d]", tx_seen), 32'(tx_ready), 32'd1);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL tx_unexpected[%0d]: got byte 0x%02h expected none", tx_seen, tx_data);
        end else begin
          mon_exp = exp_q.pop_front();
          check($sformatf("tx_byte[%0d]", tx_seen), 32'(tx_data), 32'(mon_exp));
        end
        tx_seen++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic expect_resp(input logic [7:0] rcmd, input logic [31:0] rword);
    exp_q.push_back(rcmd);
    for (int i = 3; i >= 0; i--) exp_q.push_back(rword[8*i +: 8]);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [31:0] d,
                            input logic [7:0] rcmd, input logic [31:0] rword);
    expect_resp(rcmd, rword);
    send_byte(c);
    for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
  endtask

  task automatic wait_resp(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL %s: %0d response bytes still outstanding", name, exp_q.size());
      exp_q.delete();
    end
    repeat (12) @(posedge clk);
  endtask

  task automatic wait_tx_start(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_start && n < 2000);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tx_start"},    32'(tx_start),    32'd0);
    check({tag, "_tx_data"},     32'(tx_data),     32'd0);
    check({tag, "_wr_req"},      32'(hram_wr_req), 32'd0);
    check({tag, "_rd_req"},      32'(hram_rd_req), 32'd0);
    check({tag, "_hram_addr"},   hram_addr,        32'd0);
    check({tag, "_hram_wr_d"},   hram_wr_d,        32'd0);
    check({tag, "_overrun"},     32'(overrun),     32'd0);
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    reset        = 1'b1;
    rx_data      = '0;
    rx_valid     = 1'b0;
    busy_force   = 1'b0;
    rd_rdy_force = 1'b0;
    rd_d_force   = '0;
    rd_val       = 32'hDEAD_BEEF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk);

    send_frame(8'h01, 32'h1234_5678, 8'h01, 32'h1234_5678);
    wait_resp("addr_resp");
    check("addr_reg", hram_addr, 32'h1234_5678);

    send_frame(8'h02, 32'hCAFE_BABE, 8'h02, 32'hCAFE_BABE);
    wait_resp("load_resp");
    check("wr_d_reg", hram_wr_d, 32'hCAFE_BABE);

    send_frame(8'h03, 32'h0, 8'h03, 32'h0000_0003);
    wait_tx_start(lat);
    check_range("write_latency", lat, 10, 16);
    wait_resp("write_resp");
    check("wr_req_count", 32'(wr_cnt), 32'd1);
    check("wr_d_at_req", wr_d_seen, 32'hCAFE_BABE);
    check("wr_addr_at_req", wr_addr_seen, 32'h1234_5678);

    send_frame(8'h05, 32'h0, 8'h05, 32'hDEAD_BEEF);
    wait_resp("read_req_resp");
    check("rd_req_count", 32'(rd_cnt), 32'd1);
    check("rd_addr_at_req", rd_addr_seen, 32'h1234_5678);
    send_frame(8'h04, 32'h0, 8'h04, 32'hDEAD_BEEF);
    wait_resp("read_resp");

    for (int i = 0; i < 3; i++) begin
      send_frame(8'h06, 32'h0, 8'h06, 32'(i));
      wait_resp("count_resp");
    end

    send_frame(8'h07, 32'h0, 8'h07, 32'h0000_0103);
    wait_resp("const_resp");

    send_frame(8'h09, 32'h1122_3344, 8'hFF, 32'h1122_3344);
    wait_resp("bad_cmd_resp");

    // Stalled partial frame is discarded.
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (RX_GAP + 5) @(posedge clk);
    send_frame(8'h01, 32'h0000_ABCD, 8'h01, 32'h0000_ABCD);
    wait_resp("gap_discard_resp");
    check("addr_after_gap", hram_addr, 32'h0000_ABCD);

    // A gap just short of the limit keeps the frame alive.
    expect_resp(8'h01, 32'h0000_BEEF);
    send_byte(8'h01);
    send_byte(8'h00);
    repeat (RX_GAP - 10) @(posedge clk);
    send_byte(8'h00);
    send_byte(8'hBE);
    send_byte(8'hEF);
    wait_resp("gap_keep_resp");
    check("addr_after_slow_frame", hram_addr, 32'h0000_BEEF);

    // Controller stuck busy: timeout answers EE + address, no request issued.
    busy_force = 1'b1;
    send_frame(8'h05, 32'h0, 8'hEE, 32'h0000_BEEF);
    wait_tx_start(lat);
    check_range("timeout_latency", lat, int'(HRAM_TO) - 4, int'(HRAM_TO) + 8);
    wait_resp("timeout_resp");
    busy_force = 1'b0;
    check("rd_req_count_after_timeout", 32'(rd_cnt), 32'd1);

    // Stray rd_rdy outside a read must not touch the read latch.
    @(posedge clk); #1;
    rd_d_force   = 32'h0BAD_F00D;
    rd_rdy_force = 1'b1;
    @(posedge clk); #1;
    rd_rdy_force = 1'b0;
    rd_d_force   = '0;
    send_frame(8'h04, 32'h0, 8'h04, 32'hDEAD_BEEF);
    wait_resp("read_after_timeout_resp");

    // Byte during a response sets overrun and is dropped.
    @(negedge clk);
    check("overrun_before", 32'(overrun), 32'd0);
    send_frame(8'h07, 32'h0, 8'h07, 32'h0000_0103);
    send_byte(8'h55);
    @(negedge clk);
    check("overrun_set", 32'(overrun), 32'd1);
    wait_resp("overrun_const_resp");
    send_frame(8'h01, 32'h0000_0C0D, 8'h01, 32'h0000_0C0D);
    wait_resp("addr_after_overrun");
    check("addr_after_overrun", hram_addr, 32'h0000_0C0D);
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Reset in the middle of a response.
    send_frame(8'h06, 32'h0, 8'h06, 32'h0000_0003);
    lat = 0;
    while (exp_q.size() > 3 && lat < 2000) begin
      @(posedge clk);
      lat++;
    end
    check_range("mid_resp_progress", lat, 1, 1999);
    #1 reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_idle("mid_reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (12) @(posedge clk);
    send_frame(8'h06, 32'h0, 8'h06, 32'h0000_0000);
    wait_resp("count_after_reset");
    send_frame(8'h04, 32'h0, 8'h04, 32'h0000_0000);
    wait_resp("read_after_reset");

    check("wr_req_total", 32'(wr_cnt), 32'd1);
    check("rd_req_total", 32'(rd_cnt), 32'd1);
    check("wr_rd_together", 32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
